// File: rtl/qsa_pkg.sv
// Shared definitions for the quadrature stepper axis: coil table, direction codes, x4 lookup.
// Latency: n/a (constants and a pure combinational function).
// Backpressure: n/a.
package qsa_pkg;

  typedef enum logic {NEG = 1'b0, POS = 1'b1} dir_e;

  // Phase index 0..7 -> coil pattern; odd entries energise two coils.
  localparam logic [7:0][3:0] COIL_TABLE = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0100, 4'b1100, 4'b1000
  };

  typedef struct packed {
    logic signed [1:0] delta;
    logic              illegal;
  } x4_t;

  // {A,B} walks 00->01->11->10->00 for +1. Both bits flipping at once is
  // illegal and yields no motion.
  function automatic x4_t x4_lookup(input logic [1:0] prev, input logic [1:0] cur);
    x4_t        r;
    logic [1:0] fwd;
    r.delta   = 2'sd0;
    r.illegal = 1'b0;
    case (prev)
      2'b00:   fwd = 2'b01;
      2'b01:   fwd = 2'b11;
      2'b11:   fwd = 2'b10;
      default: fwd = 2'b00;
    endcase
    if ((prev ^ cur) == 2'b11) r.illegal = 1'b1;
    else if (cur == fwd)       r.delta   = 2'sd1;
    else if (prev != cur)      r.delta   = -2'sd1;
    return r;
  endfunction

endpackage

// File: rtl/quad_stepper_axis_if.sv
// Bundle of encoder, limit, mode and motor/display/speaker signals for quad_stepper_axis.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level/free-running.
// Optional QSA_ENC_ERR_EN adds the sticky per-channel enc_err vector.
// master = environment side (drives encoders/limits), slave = axis controller.
interface quad_stepper_axis_if #(
  parameter int NUM_ENC = 2,
  parameter int POS_W   = 4
);
  logic [NUM_ENC-1:0] enc_a;
  logic [NUM_ENC-1:0] enc_b;
  logic               half_step;
  logic               lim_sup;
  logic               lim_inf;
  logic [3:0]         coil;
  logic [POS_W-1:0]   position;
  logic               busy;
  logic               dir_out;
  logic               beep;
`ifdef QSA_ENC_ERR_EN
  logic [NUM_ENC-1:0] enc_err;

  modport master (output enc_a, enc_b, half_step, lim_sup, lim_inf,
                  input  coil, position, busy, dir_out, beep, enc_err);
  modport slave  (input  enc_a, enc_b, half_step, lim_sup, lim_inf,
                  output coil, position, busy, dir_out, beep, enc_err);
`else
  modport master (output enc_a, enc_b, half_step, lim_sup, lim_inf,
                  input  coil, position, busy, dir_out, beep);
  modport slave  (input  enc_a, enc_b, half_step, lim_sup, lim_inf,
                  output coil, position, busy, dir_out, beep);
`endif
endinterface

// File: rtl/quad_decoder.sv
// One encoder channel: 2-FF synchroniser, DEB_LEN-sample debounce, x4 decode.
// Latency: input edge to delta = 2 + DEB_LEN clocks; delta/illegal are one-cycle pulses.
// Backpressure: none; every accepted transition is reported exactly once.
// Ports: clk, rst (sync, active-high), enc_a/enc_b (async), delta (signed), illegal.
module quad_decoder import qsa_pkg::*; #(
  parameter int DEB_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enc_a,
  input  logic              enc_b,
  output logic signed [1:0] delta,
  output logic              illegal
);
  localparam int CW = $clog2(DEB_LEN + 1);

  logic [1:0]    sync1, sync2, deb, cand, dec_state;
  logic [CW-1:0] cnt, cnt_nxt;
  x4_t           x4;

  // Run length of the current candidate level; a new candidate restarts at 1.
  always_comb begin
    cnt_nxt = (cnt != '0 && sync2 == cand) ? cnt + 1'b1 : CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      deb       <= '0;
      cand      <= '0;
      cnt       <= '0;
      dec_state <= '0;
    end else begin
      sync1     <= {enc_a, enc_b};
      sync2     <= sync1;
      dec_state <= deb;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt_nxt >= CW'(DEB_LEN)) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt  <= cnt_nxt;
        cand <= sync2;
      end
    end
  end

  assign x4      = x4_lookup(dec_state, deb);
  assign delta   = x4.delta;
  assign illegal = x4.illegal;

endmodule

// File: rtl/quad_stepper_axis.sv
// Merges NUM_ENC x4 encoders into a saturating signed step backlog and drives a 4-coil stepper.
// Latency: encoder edge to pending = 3 + DEB_LEN clocks; first step STEP_DIV clocks after pending != 0.
// Backpressure: none; excess requests saturate the backlog, limits clamp it per direction.
// Ports: clk, rst (sync, active-high), bus (quad_stepper_axis_if.slave).
// Optional QSA_ENC_ERR_EN: sticky per-channel illegal-transition flags on bus.enc_err.
module quad_stepper_axis import qsa_pkg::*; #(
  parameter int NUM_ENC  = 2,
  parameter int POS_W    = 4,
  parameter int PEND_W   = 6,
  parameter int STEP_DIV = 50000,
  parameter int DEB_LEN  = 4,
  parameter int BEEP_LEN = 5000000
) (
  input logic                clk,
  input logic                rst,
  quad_stepper_axis_if.slave bus
);
  // Headroom so pending + sum - step never wraps before saturation.
  localparam int SW = PEND_W + 5;
  localparam int TW = $clog2(STEP_DIV);
  localparam int BW = $clog2(BEEP_LEN + 1);
  localparam logic signed [SW-1:0] PMAX = SW'((1 << (PEND_W - 1)) - 1);

  logic signed [1:0]        delta_v [NUM_ENC];
  logic [NUM_ENC-1:0]       illegal_v;
  logic signed [SW-1:0]     sum, acc;
  logic signed [PEND_W-1:0] pending, pending_nxt;
  logic signed [1:0]        step_delta;
  logic [TW-1:0]            timer, timer_nxt;
  logic [2:0]               idx, idx_nxt;
  logic [POS_W-1:0]         pos, pos_nxt;
  logic [BW-1:0]            beep_cnt;
  logic                     step_fire, lim_sup_q, lim_inf_q, beep_trig;
  dir_e                     step_dir, dir_q;

  for (genvar g = 0; g < NUM_ENC; g++) begin : g_dec
    quad_decoder #(.DEB_LEN(DEB_LEN)) u_dec (
      .clk     (clk),
      .rst     (rst),
      .enc_a   (bus.enc_a[g]),
      .enc_b   (bus.enc_b[g]),
      .delta   (delta_v[g]),
      .illegal (illegal_v[g])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_ENC; i++) sum = sum + SW'(delta_v[i]);

    step_dir  = pending[PEND_W-1] ? NEG : POS;
    // A step due toward an active limit is dropped; the slot still elapses.
    step_fire = (pending != '0) && (timer == TW'(STEP_DIV - 1)) &&
                !((step_dir == POS) ? bus.lim_sup : bus.lim_inf);
    step_delta = !step_fire ? 2'sd0 : ((step_dir == POS) ? 2'sd1 : -2'sd1);

    acc = SW'(pending) + sum - SW'(step_delta);
    if (acc > PMAX)       acc = PMAX;
    else if (acc < -PMAX) acc = -PMAX;
    if (bus.lim_sup && !acc[SW-1] && acc != '0) acc = '0;
    if (bus.lim_inf && acc[SW-1])               acc = '0;
    pending_nxt = PEND_W'(acc);

    // Timer stays at zero whenever the backlog is (or is about to be) empty.
    if (pending == '0 || pending_nxt == '0)  timer_nxt = '0;
    else if (timer == TW'(STEP_DIV - 1))     timer_nxt = '0;
    else                                     timer_nxt = timer + 1'b1;

    // Full-step from an even (single-coil) phase takes one hop to reach a
    // two-coil phase, so switching modes never loses a step.
    idx_nxt = idx;
    pos_nxt = pos;
    if (step_fire) begin
      if (step_dir == POS) begin
        idx_nxt = idx + ((!bus.half_step && idx[0]) ? 3'd2 : 3'd1);
        pos_nxt = pos + 1'b1;
      end else begin
        idx_nxt = idx - ((!bus.half_step && idx[0]) ? 3'd2 : 3'd1);
        pos_nxt = pos - 1'b1;
      end
    end

    beep_trig = (step_fire && pos_nxt == '0) ||
                (bus.lim_sup && !lim_sup_q) || (bus.lim_inf && !lim_inf_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      timer     <= '0;
      idx       <= '0;
      pos       <= '0;
      dir_q     <= NEG;
      beep_cnt  <= '0;
      lim_sup_q <= 1'b0;
      lim_inf_q <= 1'b0;
    end else begin
      pending   <= pending_nxt;
      timer     <= timer_nxt;
      idx       <= idx_nxt;
      pos       <= pos_nxt;
      lim_sup_q <= bus.lim_sup;
      lim_inf_q <= bus.lim_inf;
      if (step_fire) dir_q <= step_dir;
      if (beep_trig)              beep_cnt <= BW'(BEEP_LEN);
      else if (beep_cnt != '0)    beep_cnt <= beep_cnt - 1'b1;
    end
  end

  assign bus.coil     = COIL_TABLE[idx];
  assign bus.position = pos;
  assign bus.busy     = (pending != '0);
  assign bus.dir_out  = dir_q;
  assign bus.beep     = (beep_cnt != '0);

`ifdef QSA_ENC_ERR_EN
  logic [NUM_ENC-1:0] enc_err_q;
  always_ff @(posedge clk) begin
    if (rst) enc_err_q <= '0;
    else     enc_err_q <= enc_err_q | illegal_v;
  end
  assign bus.enc_err = enc_err_q;
`else
  // Illegal pulses have no consumer when the error flags are not built.
  logic unused_illegal;
  assign unused_illegal = |illegal_v;
`endif

endmodule

// File: tb/tb_quad_stepper_axis.sv
// Bench for quad_stepper_axis: directed scenarios plus random encoder/limit traffic,
// every cycle compared against a behavioural model of the axis.
module tb_quad_stepper_axis;
  localparam int NE = 2, SD = 4, DL = 2, BL = 8, PMAX = 31;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  quad_stepper_axis_if #(.NUM_ENC(NE), .POS_W(4)) bus ();
  quad_stepper_axis #(.NUM_ENC(NE), .POS_W(4), .PEND_W(6), .STEP_DIV(SD),
                      .DEB_LEN(DL), .BEEP_LEN(BL)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0, n_fail = 0, cyc = 0;
  logic [3:0] coil_tab [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                               4'b0010, 4'b0011, 4'b0001, 4'b1001};

  // Behavioural model state
  int m_pend = 0, m_timer = 0, m_idx = 0, m_pos = 0, m_dir = 0, m_beep = 0;
  bit m_lsq = 0, m_liq = 0;
  logic [1:0] raw_h [NE][8];
  logic [1:0] m_deb [NE];
  logic [1:0] m_deb_old [NE];
  logic [NE-1:0] m_err = '0;
  int enc_g [NE];
  int step_q [$];
  logic [3:0] prev_pos = 4'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int gidx(input logic [1:0] v);
    case (v)
      2'b00: return 0;
      2'b01: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gval(input int g);
    case (g)
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic model_reset();
    m_pend = 0; m_timer = 0; m_idx = 0; m_pos = 0; m_dir = 0; m_beep = 0;
    m_lsq = 0; m_liq = 0; m_err = '0;
    for (int c = 0; c < NE; c++) begin
      m_deb[c] = 2'b00; m_deb_old[c] = 2'b00;
      for (int i = 0; i < 8; i++) raw_h[c][i] = 2'b00;
    end
  endtask

  // One clock edge of the axis, from the rules: a level is accepted once it has
  // been seen DL times in a row after two sync stages; the accepted level change
  // moves one Gray position (+1/-1) or two (illegal).
  task automatic model_edge();
    int sum, d, p, sg, stp;
    bit fire, all_eq, trig;
    if (rst) begin model_reset(); return; end
    sum = 0;
    for (int c = 0; c < NE; c++) begin
      d = (gidx(m_deb[c]) - gidx(m_deb_old[c]) + 4) % 4;
      if (d == 1) sum++;
      else if (d == 3) sum--;
      else if (d == 2) m_err[c] = 1'b1;
    end
    for (int c = 0; c < NE; c++) begin
      for (int i = 7; i > 0; i--) raw_h[c][i] = raw_h[c][i-1];
      raw_h[c][0] = {bus.enc_a[c], bus.enc_b[c]};
      m_deb_old[c] = m_deb[c];
      all_eq = 1;
      for (int i = 3; i <= 1 + DL; i++) if (raw_h[c][i] != raw_h[c][2]) all_eq = 0;
      if (all_eq) m_deb[c] = raw_h[c][2];
    end
    sg = (m_pend > 0) ? 1 : -1;
    fire = (m_pend != 0) && (m_timer == SD - 1) && !((sg > 0) ? bus.lim_sup : bus.lim_inf);
    p = m_pend + sum - (fire ? sg : 0);
    if (p > PMAX) p = PMAX;
    if (p < -PMAX) p = -PMAX;
    if (bus.lim_sup && p > 0) p = 0;
    if (bus.lim_inf && p < 0) p = 0;
    m_timer = (m_pend == 0 || p == 0) ? 0 : (m_timer + 1) % SD;
    trig = 0;
    if (fire) begin
      stp = (bus.half_step || (m_idx % 2 == 0)) ? 1 : 2;
      m_idx = (m_idx + sg * stp + 8) % 8;
      m_pos = (m_pos + sg + 16) % 16;
      m_dir = (sg > 0) ? 1 : 0;
      trig = (m_pos == 0);
    end
    if ((bus.lim_sup && !m_lsq) || (bus.lim_inf && !m_liq)) trig = 1;
    if (trig) m_beep = BL;
    else if (m_beep > 0) m_beep--;
    m_lsq = bus.lim_sup; m_liq = bus.lim_inf;
    m_pend = p;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check_eq("coil", bus.coil, coil_tab[m_idx]);
    check_eq("position", bus.position, m_pos);
    check_eq("busy", bus.busy, m_pend != 0);
    check_eq("dir_out", bus.dir_out, m_dir);
    check_eq("beep", bus.beep, m_beep > 0);
`ifdef QSA_ENC_ERR_EN
    check_eq("enc_err", bus.enc_err, m_err);
`endif
    if (bus.position !== prev_pos) step_q.push_back(cyc);
    prev_pos = bus.position;
  endtask

  task automatic set_raw(input int ch, input int g);
    logic [1:0] v;
    enc_g[ch] = g;
    v = gval(g);
    bus.enc_a[ch] = v[1];
    bus.enc_b[ch] = v[0];
  endtask

  task automatic enc_move(input int ch, input int dir, input int hold);
    set_raw(ch, (enc_g[ch] + dir + 4) % 4);
    repeat (hold) tick();
  endtask

  task automatic do_reset();
    set_raw(0, 0); set_raw(1, 0);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    do begin tick(); n++; end while ((bus.busy || m_pend != 0) && n < max_cyc);
    check_eq("idle_timeout", n < max_cyc, 1);
  endtask

  task automatic wait_step(input logic [3:0] from);
    int n = 0;
    while (bus.position == from && n < 40) begin tick(); n++; end
    check_eq("step_timeout", n < 40, 1);
  endtask

  initial begin
    int n, bcnt, r;
    logic [3:0] p0;
    bus.enc_a = '0; bus.enc_b = '0;
    bus.half_step = 1'b1; bus.lim_sup = 1'b0; bus.lim_inf = 1'b0;
    enc_g[0] = 0; enc_g[1] = 0;
    model_reset();

    // Reset values
    do_reset();
    check_eq("rst_coil", bus.coil, 4'b1000);
    check_eq("rst_position", bus.position, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_beep", bus.beep, 0);
    repeat (10) tick();

    // One forward cycle on enc0, half-step
    step_q.delete();
    for (int i = 0; i < 4; i++) enc_move(0, 1, 2);
    wait_idle(60);
    check_eq("fwd_position", bus.position, 4);
    check_eq("fwd_coil", bus.coil, 4'b0010);
    check_eq("fwd_dir", bus.dir_out, 1);
    check_eq("fwd_busy", bus.busy, 0);
    check_eq("fwd_nsteps", step_q.size(), 4);
    for (int i = 1; i < step_q.size(); i++) check_eq("fwd_gap", step_q[i] - step_q[i-1], 4);

    // Opposite moves cancel; then a short glitch on enc0 A is rejected
    step_q.delete();
    set_raw(0, 1); set_raw(1, 3);
    repeat (8) tick();
    bus.enc_a[0] = ~bus.enc_a[0];
    tick();
    bus.enc_a[0] = ~bus.enc_a[0];
    repeat (12) tick();
    check_eq("cancel_nsteps", step_q.size(), 0);
    check_eq("cancel_position", bus.position, 4);

    // Upper limit clears a +3 backlog and beeps for BL cycles
    step_q.delete();
    set_raw(0, 2); set_raw(1, 0);
    repeat (2) tick();
    enc_move(0, 1, 1);
    n = 0;
    while (m_pend != 3 && n < 10) begin tick(); n++; end
    check_eq("pend3_timeout", n < 10, 1);
    bus.lim_sup = 1'b1;
    bcnt = 0;
    repeat (12) begin tick(); if (bus.beep) bcnt++; end
    check_eq("lim_beep_len", bcnt, 8);
    check_eq("lim_busy", bus.busy, 0);
    check_eq("lim_nsteps", step_q.size(), 0);
    p0 = bus.position;
    enc_move(0, -1, 2);
    wait_step(p0);
    check_eq("lim_neg_position", bus.position, 3);
    check_eq("lim_neg_dir", bus.dir_out, 0);
    wait_idle(40);
    bus.lim_sup = 1'b0;
    repeat (4) tick();

    // Walk down to 15, then one positive step wraps to 0 and beeps
    for (int i = 0; i < 4; i++) enc_move(0, -1, 2);
    wait_idle(80);
    check_eq("wrap_pre_position", bus.position, 15);
    repeat (12) tick();
    check_eq("beep_quiet", bus.beep, 0);
    enc_move(0, 1, 2);
    wait_step(4'd15);
    check_eq("wrap_position", bus.position, 0);
    check_eq("wrap_beep", bus.beep, 1);
    wait_idle(40);

    // Full-step from idx 0, then back to half-step
    do_reset();
    bus.half_step = 1'b0;
    enc_move(0, 1, 2); wait_step(4'd0);
    check_eq("full1_coil", bus.coil, 4'b1100);
    enc_move(0, 1, 2); wait_step(4'd1);
    check_eq("full2_coil", bus.coil, 4'b0110);
    bus.half_step = 1'b1;
    enc_move(0, 1, 2); wait_step(4'd2);
    check_eq("half_coil", bus.coil, 4'b0010);
    wait_idle(40);

    // Illegal 00->11 on enc1
    step_q.delete();
    set_raw(1, 2);
    repeat (12) tick();
    check_eq("illegal_nsteps", step_q.size(), 0);
    check_eq("illegal_busy", bus.busy, 0);
`ifdef QSA_ENC_ERR_EN
    check_eq("enc_err_set", bus.enc_err, 2'b10);
    repeat (20) tick();
    check_eq("enc_err_sticky", bus.enc_err, 2'b10);
    do_reset();
    check_eq("enc_err_clr", bus.enc_err, 2'b00);
`else
    do_reset();
`endif

    // Random traffic against the model
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 55) begin
        n = $urandom_range(0, 2);
        enc_move($urandom_range(0, 1), (n == 0) ? -1 : ((n == 1) ? 1 : 2), $urandom_range(1, 4));
      end else if (r < 65) begin
        set_raw(0, (enc_g[0] + (($urandom_range(0, 1) == 1) ? 1 : 3)) % 4);
        set_raw(1, (enc_g[1] + (($urandom_range(0, 1) == 1) ? 1 : 3)) % 4);
        repeat ($urandom_range(2, 4)) tick();
      end else if (r < 75) begin
        bus.lim_sup = ($urandom_range(0, 4) == 0);
        bus.lim_inf = ($urandom_range(0, 4) == 0);
        tick();
      end else if (r < 80) begin
        bus.half_step = ~bus.half_step;
        tick();
      end else if (r < 82) begin
        rst = 1'b1; tick(); rst = 1'b0;
      end else begin
        repeat ($urandom_range(1, 6)) tick();
      end
    end
    bus.lim_sup = 1'b0; bus.lim_inf = 1'b0;
    wait_idle(400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/quad_stepper_axis.md
Name: quad_stepper_axis

Overview:
Parametrised axis controller that takes NUM_ENC quadrature encoders and drives one 4-coil unipolar stepper at a fixed step rate. Each encoder input is synchronised, debounced and x4-decoded, and all channels feed one signed pending-step accumulator. Limit switches gate motion per direction. Outputs are a wrapping position count for the display path and a timed beep for the speaker path.

Parameters:
NUM_ENC, 2, number of quadrature encoder channels (1..8)
POS_W, 4, width of the wrapping position counter
PEND_W, 6, width of the signed pending-step accumulator
STEP_DIV, 50000, clocks per motor step slot (>=2)
DEB_LEN, 4, consecutive equal samples required to accept an encoder level (>=1)
BEEP_LEN, 5000000, beep high time in clocks

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
enc_a  in  NUM_ENC  encoder channel A, one bit per channel, asynchronous
enc_b  in  NUM_ENC  encoder channel B, one bit per channel, asynchronous
half_step  in  1  1 = half-step sequence, 0 = full-step, two coils on
lim_sup  in  1  upper limit active-high; blocks positive motion
lim_inf  in  1  lower limit active-high; blocks negative motion
coil  out  4  unipolar coil drive
position  out  POS_W  step position, wraps modulo 2^POS_W
busy  out  1  pending != 0
dir_out  out  1  direction of last executed step, 1 = positive
beep  out  1  speaker enable

Behaviour:
- Clock/reset: one clock `clk`. Reset `rst` is synchronous and active-high. All state clears on the `clk` edge where rst=1.
- Reset values: coil=4'b1000 (idx 0), position=0, busy=0, dir_out=0, beep=0, pending=0, step timer=0. Debounced levels are loaded as 0 and the decoders hold their previous state 00.
- Input path, per channel: 2-FF synchroniser, then debounce. The debounced level updates only after DEB_LEN consecutive equal synchronised samples.
- x4 decode, per channel, on the debounced {A,B}:
  - 00->01->11->10->00 = +1.
  - Reverse order = -1.
  - No change = 0.
  - Both bits changed = illegal: delta 0, decoder state still updates.
  - Input-to-delta latency = 2 + DEB_LEN clocks.
- Merge: sum = signed sum of all channel deltas in the same cycle.
- Accumulator update: pending_next = sat(pending + sum - executed_step). Saturation is at ±(2^(PEND_W-1)-1).
- Limits, applied after the merge in the same cycle:
  - lim_sup=1: pending is clamped to <=0.
  - lim_inf=1: pending is clamped to >=0.
  - Both high: pending=0 and no step executes.
- Step timer:
  - Held at 0 while pending==0.
  - Otherwise counts 0..STEP_DIV-1. At terminal count it executes one step in sign(pending) and wraps to 0.
  - First step occurs STEP_DIV clocks after pending becomes nonzero.
  - A step is suppressed if the limit for its direction is high in that cycle.
- Step execution:
  - idx is a 3-bit phase index. Coil table, idx 0..7: 1000,1100,0100,0110,0010,0011,0001,1001.
  - Half-step: idx ± 1 mod 8.
  - Full-step: idx ± 2 if idx is odd, else idx ± 1. This lands on an odd index (two coils on). Mode may change between steps without losing position.
  - position ± 1 mod 2^POS_W; dir_out updates to the step direction.
- Beep triggers:
  - a step that lands position on 0 (including wrap-around);
  - rising edge of lim_sup or lim_inf.
  - Trigger loads the beep counter with BEEP_LEN; beep=1 while counter>0.
  - Retrigger while active reloads the counter.
- Reset mid-step or mid-beep: everything returns to reset values next cycle and in-flight deltas are discarded.

Optional Feature:
QSA_ENC_ERR_EN
- Defined: adds output enc_err[NUM_ENC-1:0]. The per-channel bit sets sticky on an illegal transition and clears only on rst.
- Undefined: port and logic are absent; illegal transitions are silently ignored (delta 0).

Decomposition:
- Package qsa_pkg holds:
  - the 8-entry coil table constant;
  - direction encodings POS/NEG;
  - the x4 transition lookup returning a signed 2-bit delta plus an illegal flag.
- Sub-module quad_decoder (synchroniser + debounce + x4 decode), instanced NUM_ENC times via generate. Outputs: signed 2-bit delta, illegal pulse.

Test Plan:
Bench parameters: STEP_DIV=4, DEB_LEN=2, BEEP_LEN=8, POS_W=4, NUM_ENC=2.
- Reset: hold rst 2 cycles -> coil=1000, position=0, busy=0, beep=0; all outputs stable afterwards with encoders idle.
- Encoder 0, one full forward cycle (00,01,11,10,00), half_step=1 -> pending reaches +4, 4 steps 4 clocks apart, coil 1100,0100,0110,0010, position=4, dir_out=1, busy drops after the last step.
- Enc0 +1 and enc1 -1 in the same cycle -> pending unchanged, no step. Then a glitch on enc0 A shorter than DEB_LEN -> no delta.
- lim_sup=1 with pending=+3 -> pending cleared, no step, beep high exactly 8 cycles. Negative steps still execute while lim_sup=1.
- Position wrap: from position=15 one positive step -> position=0 and beep asserted.
- Full-step from idx 0: two steps -> coil 1100 then 0110. Then switch to half_step=1, one step -> coil 0010.
- Illegal 00->11 on enc1 -> no delta. With QSA_ENC_ERR_EN defined, enc_err=2'b10, and it stays set until rst.
